// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : interrupt_controller
// Purpose  : IF/IE registers, IME with EI delay, HALT wake-up and the
//            fixed-priority 4-M-cycle interrupt dispatch sequencer.
//            Optional macro HALT_BUG_EN enables the o_Halt_Bug pulse.
// Revision : 1.0 - initial release
// ============================================================================
module interrupt_controller #(
   parameter int NUM_SOURCES = 5
) (
   input  logic                   i_Clk,
   input  logic                   i_Reset,
   input  logic [3:0]             i_Cycle_Step,
   input  logic                   i_Instruction_Boundary,
   input  logic [NUM_SOURCES-1:0] i_Interrupt_Request,
   input  logic                   i_IF_Select,
   input  logic                   i_IE_Select,
   input  logic                   i_Write,
   input  logic [7:0]             i_Data,
   output logic [7:0]             o_Data,
   input  logic                   i_EI,
   input  logic                   i_DI,
   input  logic                   i_RETI,
   input  logic                   i_Halt,
   input  logic                   i_Ack,
   output logic                   o_Dispatch_Active,
   output logic [7:0]             o_Cycle_Count,
   output logic [2:0]             o_Interrupt_Address,
   output logic                   o_IME,
   output logic                   o_Halted,
   output logic                   o_Halt_Bug
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_HALTED   = 2'd1,
      S_DISPATCH = 2'd2
   } state_t;

   state_t                 r_State, w_State_Next;
   logic [NUM_SOURCES-1:0] r_IF, w_IF_Next, r_Req_Prev, w_Rise, w_Pending;
   logic [7:0]             r_IE;
   logic                   r_IME, r_EI_Delay, w_Eff_En, w_Tick, w_Any;
   logic [3:0]             r_Count, w_Count_Next;
   logic [2:0]             r_Index, w_Index_Next, w_Select;
   logic                   w_Halt_Skip;
   logic                   w_unused_bits;

   assign w_Tick    = i_Instruction_Boundary & i_Cycle_Step[3];
   assign w_Rise    = i_Interrupt_Request & ~r_Req_Prev;
   assign w_Pending = r_IF & r_IE[NUM_SOURCES-1:0];
   assign w_Any     = |w_Pending;
   assign w_Eff_En  = r_IME | r_EI_Delay;

   // Lowest set bit wins: scan from the top so the last hit is the lowest.
   always_comb begin
      w_Select = 3'd0;
      for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
         if (w_Pending[i]) w_Select = 3'(i);
      end
   end

   // Precedence per bit: request edge > register write > acknowledge.
   always_comb begin
      w_IF_Next = r_IF;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         if (i_Ack && (r_Index == 3'(i))) w_IF_Next[i] = 1'b0;
      end
      if (i_Write && i_IF_Select) w_IF_Next = i_Data[NUM_SOURCES-1:0];
      w_IF_Next = w_IF_Next | w_Rise;
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         r_IF       <= '0;
         r_Req_Prev <= '0;
         r_IE       <= 8'h00;
      end else begin
         r_IF       <= w_IF_Next;
         r_Req_Prev <= i_Interrupt_Request;
         if (i_Write && i_IE_Select) r_IE <= i_Data;
      end
   end

   assign o_Data = i_IF_Select ? {{(8 - NUM_SOURCES){1'b1}}, r_IF} :
                   i_IE_Select ? r_IE : 8'h00;

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         r_IME      <= 1'b0;
         r_EI_Delay <= 1'b0;
      end else if (i_DI) begin
         r_IME      <= 1'b0;
         r_EI_Delay <= 1'b0;
      end else begin
         if (i_RETI) r_IME <= 1'b1;
         if (w_Tick) begin
            if (r_EI_Delay) begin
               r_IME      <= 1'b1;
               r_EI_Delay <= 1'b0;
            end
            if (i_EI) r_EI_Delay <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         r_State <= S_IDLE;
         r_Count <= 4'h0;
         r_Index <= 3'd0;
      end else begin
         r_State <= w_State_Next;
         r_Count <= w_Count_Next;
         r_Index <= w_Index_Next;
      end
   end

   always_comb begin
      w_State_Next = r_State;
      w_Count_Next = r_Count;
      w_Index_Next = r_Index;
      w_Halt_Skip  = 1'b0;
      case (r_State)
         S_IDLE: begin
            if (w_Tick) begin
               if (w_Eff_En && w_Any) begin
                  w_State_Next = S_DISPATCH;
                  w_Index_Next = w_Select;
                  w_Count_Next = 4'h1;
               end else if (i_Halt && !w_Any) begin
                  w_State_Next = S_HALTED;
               end else if (i_Halt) begin
                  w_Halt_Skip = 1'b1;
               end
            end
         end
         S_HALTED: begin
            if (i_Cycle_Step[3] && w_Any) begin
               if (r_IME) begin
                  w_State_Next = S_DISPATCH;
                  w_Index_Next = w_Select;
                  w_Count_Next = 4'h1;
               end else begin
                  w_State_Next = S_IDLE;
               end
            end
         end
         S_DISPATCH: begin
            if (i_Cycle_Step[3]) begin
               if (r_Count == 4'h8) begin
                  w_State_Next = S_IDLE;
                  w_Count_Next = 4'h0;
               end else begin
                  w_Count_Next = r_Count << 1;
               end
            end
         end
         default: begin
            w_State_Next = S_IDLE;
            w_Count_Next = 4'h0;
         end
      endcase
   end

   assign o_Dispatch_Active   = (r_State == S_DISPATCH);
   assign o_Halted            = (r_State == S_HALTED);
   assign o_Cycle_Count       = {4'h0, r_Count};
   assign o_Interrupt_Address = r_Index;
   assign o_IME               = r_IME;

`ifdef HALT_BUG_EN
   assign o_Halt_Bug    = w_Halt_Skip & ~r_IME;
   assign w_unused_bits = ^i_Cycle_Step[2:0];
`else
   assign o_Halt_Bug    = 1'b0;
   assign w_unused_bits = ^{i_Cycle_Step[2:0], w_Halt_Skip};
`endif

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_interrupt_controller
// Purpose  : directed self-checking bench for interrupt_controller
// Revision : 1.0 - initial release
// ============================================================================
module tb_interrupt_controller;

   logic       i_Clk = 1'b0;
   logic       i_Reset;
   logic [3:0] i_Cycle_Step;
   logic       i_Instruction_Boundary;
   logic [4:0] i_Interrupt_Request;
   logic       i_IF_Select, i_IE_Select, i_Write;
   logic [7:0] i_Data;
   logic [7:0] o_Data;
   logic       i_EI, i_DI, i_RETI, i_Halt, i_Ack;
   logic       o_Dispatch_Active;
   logic [7:0] o_Cycle_Count;
   logic [2:0] o_Interrupt_Address;
   logic       o_IME, o_Halted, o_Halt_Bug;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] v;
   logic       hb;

`ifdef HALT_BUG_EN
   localparam logic HB_EXP = 1'b1;
`else
   localparam logic HB_EXP = 1'b0;
`endif

   interrupt_controller #(.NUM_SOURCES(5)) dut (
      .i_Clk                  (i_Clk),
      .i_Reset                (i_Reset),
      .i_Cycle_Step           (i_Cycle_Step),
      .i_Instruction_Boundary (i_Instruction_Boundary),
      .i_Interrupt_Request    (i_Interrupt_Request),
      .i_IF_Select            (i_IF_Select),
      .i_IE_Select            (i_IE_Select),
      .i_Write                (i_Write),
      .i_Data                 (i_Data),
      .o_Data                 (o_Data),
      .i_EI                   (i_EI),
      .i_DI                   (i_DI),
      .i_RETI                 (i_RETI),
      .i_Halt                 (i_Halt),
      .i_Ack                  (i_Ack),
      .o_Dispatch_Active      (o_Dispatch_Active),
      .o_Cycle_Count          (o_Cycle_Count),
      .o_Interrupt_Address    (o_Interrupt_Address),
      .o_IME                  (o_IME),
      .o_Halted               (o_Halted),
      .o_Halt_Bug             (o_Halt_Bug)
   );

   always #5 i_Clk = ~i_Clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock; inputs change 1 ns after the edge and the T-step rotates.
   task automatic clk1();
      @(posedge i_Clk);
      #1;
      i_Cycle_Step = {i_Cycle_Step[2:0], i_Cycle_Step[3]};
   endtask

   task automatic align();
      while (i_Cycle_Step != 4'b0001) clk1();
   endtask

   // One M-cycle from T-step 0; strobes sit in the last T-step, ack in the first.
   task automatic mcyc(input logic bnd, input logic ei, input logic di,
                       input logic reti, input logic halt, input logic ack,
                       output logic hbo);
      hbo = 1'b0;
      for (int k = 0; k < 4; k++) begin
         i_Instruction_Boundary = bnd;
         i_Ack = ack && (k == 0);
         if (k == 3) begin
            i_EI = ei; i_DI = di; i_RETI = reti; i_Halt = halt;
            #1;
            hbo = o_Halt_Bug;
         end
         clk1();
      end
      i_Instruction_Boundary = 0; i_Ack = 0;
      i_EI = 0; i_DI = 0; i_RETI = 0; i_Halt = 0;
   endtask

   task automatic wr(input logic sel_if, input logic [7:0] d);
      i_IF_Select = sel_if; i_IE_Select = !sel_if; i_Write = 1'b1; i_Data = d;
      clk1();
      i_IF_Select = 0; i_IE_Select = 0; i_Write = 0; i_Data = 8'h00;
   endtask

   task automatic rd(input logic sel_if, output logic [7:0] val);
      i_IF_Select = sel_if; i_IE_Select = !sel_if;
      #1;
      val = o_Data;
      i_IF_Select = 0; i_IE_Select = 0;
   endtask

   task automatic pulse_reti();
      i_RETI = 1'b1; clk1(); i_RETI = 1'b0;
   endtask

   initial begin
      i_Reset = 1; i_Cycle_Step = 4'b0001; i_Instruction_Boundary = 0;
      i_Interrupt_Request = 0; i_IF_Select = 0; i_IE_Select = 0; i_Write = 0;
      i_Data = 0; i_EI = 0; i_DI = 0; i_RETI = 0; i_Halt = 0; i_Ack = 0;
      clk1(); clk1();
      #1;
      chk("rst_active", {7'd0, o_Dispatch_Active}, 8'h00);
      chk("rst_count", o_Cycle_Count, 8'h00);
      chk("rst_addr", {5'd0, o_Interrupt_Address}, 8'h00);
      chk("rst_ime", {7'd0, o_IME}, 8'h00);
      chk("rst_halted", {7'd0, o_Halted}, 8'h00);
      chk("rst_hbug", {7'd0, o_Halt_Bug}, 8'h00);
      rd(1, v); chk("rst_if_read", v, 8'hE0);
      rd(0, v); chk("rst_ie_read", v, 8'h00);
      i_Reset = 0;
      i_Cycle_Step = 4'b0001;

      // Priority: sources 2 and 4 pending, 2 wins
      wr(0, 8'h1F);
      rd(0, v); chk("ie_write", v, 8'h1F);
      i_Interrupt_Request = 5'h14;
      clk1();
      rd(1, v); chk("if_edges", v, 8'hF4);
      pulse_reti();
      chk("reti_ime", {7'd0, o_IME}, 8'h01);
      align();
      mcyc(1, 0, 0, 0, 0, 0, hb);
      chk("prio_active", {7'd0, o_Dispatch_Active}, 8'h01);
      chk("prio_addr", {5'd0, o_Interrupt_Address}, 8'h02);
      chk("prio_cnt1", o_Cycle_Count, 8'h01);
      mcyc(0, 0, 0, 0, 0, 1, hb);
      chk("prio_cnt2", o_Cycle_Count, 8'h02);
      rd(1, v); chk("prio_ack_if", v, 8'hF0);
      mcyc(0, 0, 0, 0, 0, 0, hb);
      chk("prio_cnt4", o_Cycle_Count, 8'h04);
      mcyc(0, 0, 0, 0, 0, 0, hb);
      chk("prio_cnt8", o_Cycle_Count, 8'h08);
      chk("prio_still_active", {7'd0, o_Dispatch_Active}, 8'h01);
      mcyc(0, 0, 1, 0, 0, 0, hb);
      chk("prio_cnt0", o_Cycle_Count, 8'h00);
      chk("prio_done", {7'd0, o_Dispatch_Active}, 8'h00);
      chk("prio_di_ime", {7'd0, o_IME}, 8'h00);

      // EI delay
      wr(1, 8'h01);
      wr(0, 8'h01);
      align();
      mcyc(1, 1, 0, 0, 0, 0, hb);
      chk("ei_k_no_disp", {7'd0, o_Dispatch_Active}, 8'h00);
      chk("ei_k_ime", {7'd0, o_IME}, 8'h00);
      mcyc(1, 0, 0, 0, 0, 0, hb);
      chk("ei_k1_disp", {7'd0, o_Dispatch_Active}, 8'h01);
      chk("ei_k1_addr", {5'd0, o_Interrupt_Address}, 8'h00);
      chk("ei_k1_ime", {7'd0, o_IME}, 8'h01);
      mcyc(0, 0, 0, 0, 0, 1, hb);
      chk("ei_ime_hold", {7'd0, o_IME}, 8'h01);
      mcyc(0, 0, 1, 0, 0, 0, hb);
      chk("ei_di_ime", {7'd0, o_IME}, 8'h00);
      mcyc(0, 0, 0, 0, 0, 0, hb);
      mcyc(0, 0, 0, 0, 0, 0, hb);
      chk("ei_done", {7'd0, o_Dispatch_Active}, 8'h00);
      rd(1, v); chk("ei_if_clear", v, 8'hE0);

      // HALT wake with IME = 1
      i_Interrupt_Request = 5'h00;
      wr(0, 8'h04);
      pulse_reti();
      align();
      mcyc(1, 0, 0, 0, 1, 0, hb);
      chk("halt_enter", {7'd0, o_Halted}, 8'h01);
      i_Interrupt_Request = 5'h04;
      clk1();
      chk("halt_hold", {7'd0, o_Halted}, 8'h01);
      clk1(); clk1(); clk1();
      chk("wake_halted", {7'd0, o_Halted}, 8'h00);
      chk("wake_disp", {7'd0, o_Dispatch_Active}, 8'h01);
      chk("wake_addr", {5'd0, o_Interrupt_Address}, 8'h02);
      mcyc(0, 0, 0, 0, 0, 1, hb);
      mcyc(0, 0, 0, 0, 0, 0, hb);
      mcyc(0, 0, 0, 0, 0, 0, hb);
      mcyc(0, 0, 1, 0, 0, 0, hb);
      chk("wake_done", {7'd0, o_Dispatch_Active}, 8'h00);

      // HALT wake with IME = 0
      mcyc(1, 0, 0, 0, 1, 0, hb);
      chk("halt2_enter", {7'd0, o_Halted}, 8'h01);
      i_Interrupt_Request = 5'h00;
      clk1();
      i_Interrupt_Request = 5'h04;
      clk1(); clk1(); clk1();
      chk("wake2_halted", {7'd0, o_Halted}, 8'h00);
      chk("wake2_no_disp", {7'd0, o_Dispatch_Active}, 8'h00);
      rd(1, v); chk("wake2_if", v, 8'hE4);

      // HALT with IME = 0 and an interrupt pending
      wr(1, 8'h01);
      wr(0, 8'h01);
      align();
      mcyc(1, 0, 0, 0, 1, 0, hb);
      chk("hbug_pulse", {7'd0, hb}, {7'd0, HB_EXP});
      chk("hbug_no_halt", {7'd0, o_Halted}, 8'h00);
      chk("hbug_after", {7'd0, o_Halt_Bug}, 8'h00);

      // IE and IF change mid-dispatch
      i_Interrupt_Request = 5'h00;
      wr(0, 8'h04);
      wr(1, 8'h04);
      pulse_reti();
      align();
      mcyc(1, 0, 0, 0, 0, 0, hb);
      chk("mid_addr0", {5'd0, o_Interrupt_Address}, 8'h02);
      i_IE_Select = 1; i_Write = 1; i_Data = 8'h00; i_Interrupt_Request = 5'h01;
      clk1();
      i_IE_Select = 0; i_Write = 0;
      align();
      chk("mid_cnt2", o_Cycle_Count, 8'h02);
      chk("mid_addr1", {5'd0, o_Interrupt_Address}, 8'h02);
      rd(0, v); chk("mid_ie", v, 8'h00);
      mcyc(0, 0, 0, 0, 0, 1, hb);
      mcyc(0, 0, 0, 0, 0, 0, hb);
      mcyc(0, 0, 0, 0, 0, 0, hb);
      chk("mid_done", {7'd0, o_Dispatch_Active}, 8'h00);
      chk("mid_addr_end", {5'd0, o_Interrupt_Address}, 8'h02);
      rd(1, v); chk("mid_if", v, 8'hE1);
      i_DI = 1; clk1(); i_DI = 0;
      chk("mid_di", {7'd0, o_IME}, 8'h00);

      // Same-cycle conflicts on IF bit 2 (latched index is 2)
      i_Interrupt_Request = 5'h05;
      i_IF_Select = 1; i_Write = 1; i_Data = 8'h00; i_Ack = 1;
      clk1();
      i_IF_Select = 0; i_Write = 0; i_Ack = 0;
      rd(1, v); chk("conf_set_wins", v, 8'hE4);
      wr(1, 8'h00);
      i_IF_Select = 1; i_Write = 1; i_Data = 8'h04; i_Ack = 1;
      clk1();
      i_IF_Select = 0; i_Write = 0; i_Ack = 0;
      rd(1, v); chk("conf_write_wins", v, 8'hE4);

      // Reset mid-dispatch
      wr(0, 8'h04);
      pulse_reti();
      align();
      mcyc(1, 0, 0, 0, 0, 0, hb);
      mcyc(0, 0, 0, 0, 0, 0, hb);
      mcyc(0, 0, 0, 0, 0, 0, hb);
      chk("rst2_pre_cnt", o_Cycle_Count, 8'h04);
      i_Reset = 1;
      #1;
      chk("rst2_active", {7'd0, o_Dispatch_Active}, 8'h00);
      chk("rst2_count", o_Cycle_Count, 8'h00);
      chk("rst2_addr", {5'd0, o_Interrupt_Address}, 8'h00);
      chk("rst2_ime", {7'd0, o_IME}, 8'h00);
      chk("rst2_halted", {7'd0, o_Halted}, 8'h00);
      rd(1, v); chk("rst2_if", v, 8'hE0);
      clk1();
      i_Reset = 0;
      clk1();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
